debounce_sync: RTL and testbench

//  Input-conditioning stage that feeds the async-reset D flip-flop's d input.

---
 rtl/debounce_sync_pkg.sv | 31 +++
 rtl/debounce_sync_sync_chain.sv | 44 ++++
 rtl/debounce_sync.sv | 153 +++++++++++++++
 tb/tb_debounce_sync.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_sync_pkg.sv
// -----------------------------------------------------------------------------
// debounce_sync_pkg
//   Shared definitions for the input-conditioning blocks.
//   - dbnc_state_e : 2-bit FSM encoding used by the debouncer and any later
//                    conditioning stage that qualifies level changes.
//   - dbnc_stable_state() : maps a settled level to its STABLE_* state.
//   - dbnc_is_checking()  : true while a candidate change is being qualified.
// -----------------------------------------------------------------------------
package debounce_sync_pkg;

  localparam int DBNC_STATE_W = 2;

  typedef enum logic [DBNC_STATE_W-1:0] {
    ST_STABLE_LO = 2'b00,
    ST_CHK_HI    = 2'b01,
    ST_STABLE_HI = 2'b10,
    ST_CHK_LO    = 2'b11
  } dbnc_state_e;

  // Settled state for a given output level.
  function automatic dbnc_state_e dbnc_stable_state(input logic level);
    return level ? ST_STABLE_HI : ST_STABLE_LO;
  endfunction

  // Both CHK_* states share bit 0 = 1, but spell it out so the encoding can
  // change without breaking callers.
  function automatic logic dbnc_is_checking(input dbnc_state_e st);
    return (st == ST_CHK_HI) || (st == ST_CHK_LO);
  endfunction

endpackage : debounce_sync_pkg

// File: rtl/debounce_sync_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   N-flop synchroniser bringing an asynchronous level into the clk domain.
//   One async-reset flop per stage, nothing between stages.
// Parameters
//   STAGES    : number of flops (>= 2)
//   RESET_VAL : value every stage takes while rst_n is low
// Ports
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input level
//   q     out synchronised level (last stage)
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_q[gi] <= RESET_VAL;
          else        stage_q[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_q[gi] <= RESET_VAL;
          else        stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_q[STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//   Synchronises a raw asynchronous level, rejects bounce by requiring
//   STABLE_CYCLES consecutive agreeing synchronised samples, and drives a clean
//   registered level plus one-cycle rise/fall pulses.
// Parameters
//   SYNC_STAGES   : synchroniser depth (>= 2)
//   STABLE_CYCLES : consecutive samples a new level must hold (>= 2)
//   INIT_LEVEL    : reset value of synchroniser and q (0 or 1)
// Ports
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   d_raw in  unsynchronised input level
//   q     out debounced level
//   rise  out one-cycle pulse on the edge q goes 0->1
//   fall  out one-cycle pulse on the edge q goes 1->0
//   busy  out high while a candidate level change is being qualified
// Every output comes straight from a flop; d_raw only reaches them through
// the synchroniser and FSM registers.
// -----------------------------------------------------------------------------
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int INIT_LEVEL    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_raw,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int   CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic INIT_BIT = (INIT_LEVEL != 0);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The qualifying sample is the STABLE_CYCLES-th one; the first was already
  // counted on entry to CHK_*, so the compare value is STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic s;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (INIT_BIT)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d_raw),
    .q     (s)
  );

  dbnc_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             q_q,     q_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic             busy_q,  busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= dbnc_stable_state(INIT_BIT);
      cnt_q   <= CNT_ZERO;
      q_q     <= INIT_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      ST_STABLE_LO: begin
        if (s) begin
          state_d = ST_CHK_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      ST_CHK_HI: begin
        if (!s) begin
          // Reverted before qualifying: glitch, no pulse.
          state_d = ST_STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_HI;
          q_d     = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      ST_STABLE_HI: begin
        if (!s) begin
          state_d = ST_CHK_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      ST_CHK_LO: begin
        if (s) begin
          state_d = ST_STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LO;
          q_d     = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = dbnc_stable_state(q_q);
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Registered busy tracks the state being entered so it lines up with it.
    busy_d = dbnc_is_checking(state_d);
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule : debounce_sync

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//   Directed scenarios plus random run-length stimulus on d_raw, checked
//   against a reference model: the level the FSM sees is the raw sample taken
//   SYNC_STAGES edges earlier, and q flips once STABLE_CYCLES consecutive seen
//   samples disagree with it.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int INIT_LEVEL    = 0;

  logic clk;
  logic rst_n;
  logic d_raw;
  logic q, rise, fall, busy;

  debounce_sync #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .INIT_LEVEL    (INIT_LEVEL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d_raw (d_raw),
    .q     (q),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  logic hist[$];      // raw samples taken at each edge since reset release
  logic m_q;
  int   m_run;        // consecutive seen samples disagreeing with m_q
  logic m_rise, m_fall, m_busy;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_q    = (INIT_LEVEL != 0);
    m_run  = 0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic model_step(input logic d);
    logic seen;
    hist.push_back(d);
    if (hist.size() > SYNC_STAGES) seen = hist[hist.size()-1-SYNC_STAGES];
    else                           seen = (INIT_LEVEL != 0);
    if (hist.size() > SYNC_STAGES + 1) void'(hist.pop_front());
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (seen != m_q) begin
      m_run++;
      if (m_run == STABLE_CYCLES) begin
        m_q    = seen;
        m_run  = 0;
        m_rise = seen;
        m_fall = !seen;
      end
    end else begin
      m_run = 0;
    end
    m_busy = (m_run != 0);
  endtask

  task automatic check_all(input string where);
    chk({where, ".q"},    q,    m_q);
    chk({where, ".rise"}, rise, m_rise);
    chk({where, ".fall"}, fall, m_fall);
    chk({where, ".busy"}, busy, m_busy);
  endtask

  // One clock: drive d, let the edge happen, sample 1 ns later.
  task automatic cycle(input logic d);
    d_raw = d;
    @(posedge clk);
    #1;
    cyc++;
    model_step(d);
    $display("cyc %0d d=%b q=%b rise=%b fall=%b busy=%b", cyc, d, q, rise, fall, busy);
    check_all("model");
  endtask

  // Assert reset between edges, check the asynchronous clear, release on a
  // falling edge with d_raw changing at the same moment.
  task automatic mid_reset(input logic d_after);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    d_raw = d_after;
    rst_n = 1'b1;
  endtask

  initial begin
    logic cur;
    int   len;

    // 1: reset with d_raw=1 before any clock edge
    rst_n = 1'b0;
    d_raw = 1'b1;
    #1;
    model_reset();
    check_all("t1_rst");

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: rise after full latency
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1);
      if (i == 3) chk("t2_busy_e3", busy, 1'b1);
      if (i == 5) chk("t2_q_e5", q, 1'b0);
      if (i == 6) chk("t2_rise_e6", rise, 1'b1);
      if (i == 7) chk("t2_rise_e7", rise, 1'b0);
    end

    // 6: fall after full latency
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0);
      if (i == 6) chk("t6_fall_e6", fall, 1'b1);
      if (i == 6) chk("t6_q_e6", q, 1'b0);
    end

    // 3: short high pulse rejected
    for (int i = 0; i < 3; i++) cycle(1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0);
    chk("t3_q_low", q, 1'b0);
    chk("t3_busy_idle", busy, 1'b0);

    // 4: bounce then settle high
    for (int i = 0; i < 10; i++) cycle((i % 2) == 0);
    chk("t4_q_bounce", q, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1);
      if (i == 6) chk("t4_rise_e6", rise, 1'b1);
    end

    // 5: reset in the middle of qualifying a fall (cnt=2)
    for (int i = 0; i < 4; i++) cycle(1'b0);
    chk("t5_busy_pre", busy, 1'b1);
    mid_reset(1'b1);
    chk("t5_q_rst", q, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cycle(1'b1);
      if (i == 5) chk("t5_q_e5", q, 1'b0);
      if (i == 6) chk("t5_rise_e6", rise, 1'b1);
    end

    // Random run-length stimulus with occasional resets
    cur = 1'b0;
    for (int r = 0; r < 300; r++) begin
      cur = ~cur;
      len = (($urandom % 4) == 0) ? int'($urandom_range(4, 9))
                                  : int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) cycle(cur);
      if (($urandom % 40) == 0) mid_reset($urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_debounce_sync
